// File: rtl/rom_ram_copy_ctrl_if.sv
// Shared ROM/RAM control bus: one address, per-memory chip-select/enables, and ROM read data.
// DATA_ram is bidirectional and stays a plain port on the controller.
interface rom_ram_copy_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] ADDR;
    logic              CS_rom;
    logic              OE_rom;
    logic [DATA_W-1:0] DATA_rom;
    logic              CS_ram;
    logic              OE_ram;
    logic              WS_ram;

    modport master (
        output ADDR, CS_rom, OE_rom, CS_ram, OE_ram, WS_ram,
        input  DATA_rom
    );

    modport slave (
        input  ADDR, CS_rom, OE_rom, CS_ram, OE_ram, WS_ram,
        output DATA_rom
    );
endinterface

// File: rtl/rom_ram_copy_ctrl.sv
// Copies a ROM address window into RAM with a fixed per-byte bit permutation,
// optionally reading the window back and counting mismatches.
module rom_ram_copy_ctrl #(
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(4),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(30)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                verify_en,
    output logic                busy,
    output logic                done,
    output logic [7:0]          err_cnt,
    rom_ram_copy_ctrl_if.master mem,
    inout  wire  [DATA_W-1:0]   DATA_ram
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WR_END,
        S_VRD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [7:0]        r_err_cnt;
    logic              r_verify;
    logic              r_busy;
    logic              r_done;
    logic              r_cs_rom;
    logic              r_oe_rom;
    logic              r_cs_ram;
    logic              r_oe_ram;
    logic              r_ws_ram;
    logic              r_drv;

    logic              w_busy;
    logic              w_done;
    logic              w_cs_rom;
    logic              w_oe_rom;
    logic              w_cs_ram;
    logic              w_oe_ram;
    logic              w_ws_ram;
    logic              w_drv;
    logic [DATA_W-1:0] w_perm;

    function automatic logic [DATA_W-1:0] f_perm(input logic [DATA_W-1:0] d);
        return {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]};
    endfunction

    assign w_perm = f_perm(mem.DATA_rom);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the next state and registered, so each strobe
    // is glitch-free and valid for exactly the cycle its state occupies.
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_cs_rom = 1'b1;
        w_oe_rom = 1'b0;
        w_cs_ram = 1'b1;
        w_oe_ram = 1'b0;
        w_ws_ram = 1'b0;
        w_drv    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (START_ADDR > END_ADDR) ? S_DONE : S_RD;
                end
            end
            S_RD:     w_next = S_WR;
            S_WR:     w_next = S_WR_END;
            S_WR_END: begin
                if (r_addr == END_ADDR) begin
                    w_next = r_verify ? S_VRD : S_DONE;
                end else begin
                    w_next = S_RD;
                end
            end
            S_VRD: begin
                if (r_addr == END_ADDR) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        case (w_next)
            S_RD: begin
                w_busy   = 1'b1;
                w_cs_rom = 1'b0;
                w_oe_rom = 1'b1;
            end
            S_WR: begin
                w_busy   = 1'b1;
                w_cs_ram = 1'b0;
                w_ws_ram = 1'b1;
                w_drv    = 1'b1;
            end
            S_WR_END: begin
                w_busy   = 1'b1;
                w_cs_ram = 1'b0;
                w_drv    = 1'b1;
            end
            S_VRD: begin
                w_busy   = 1'b1;
                w_cs_rom = 1'b0;
                w_oe_rom = 1'b1;
                w_cs_ram = 1'b0;
                w_oe_ram = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= START_ADDR;
            r_wr_data <= '0;
            r_err_cnt <= '0;
            r_verify  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_rom  <= 1'b1;
            r_oe_rom  <= 1'b0;
            r_cs_ram  <= 1'b1;
            r_oe_ram  <= 1'b0;
            r_ws_ram  <= 1'b0;
            r_drv     <= 1'b0;
        end else begin
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_cs_rom <= w_cs_rom;
            r_oe_rom <= w_oe_rom;
            r_cs_ram <= w_cs_ram;
            r_oe_ram <= w_oe_ram;
            r_ws_ram <= w_ws_ram;
            r_drv    <= w_drv;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= START_ADDR;
                        r_err_cnt <= '0;
                        r_verify  <= verify_en;
                    end
                end
                S_RD: r_wr_data <= w_perm;
                S_WR_END: begin
                    // The last address leaves ADDR parked on END_ADDR unless a readback follows.
                    if (r_addr == END_ADDR) begin
                        if (r_verify) begin
                            r_addr <= START_ADDR;
                        end
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_VRD: begin
                    if ((DATA_ram != w_perm) && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    if (r_addr != END_ADDR) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err_cnt    = r_err_cnt;
    assign mem.ADDR   = r_addr;
    assign mem.CS_rom = r_cs_rom;
    assign mem.OE_rom = r_oe_rom;
    assign mem.CS_ram = r_cs_ram;
    assign mem.OE_ram = r_oe_ram;
    assign mem.WS_ram = r_ws_ram;
    assign DATA_ram   = r_drv ? r_wr_data : 'z;

endmodule

// File: tb/tb_rom_ram_copy_ctrl.sv
// Directed bench for rom_ram_copy_ctrl with behavioural ROM/RAM models and
// a second instance overridden to an empty window.
module tb_rom_ram_copy_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       verify_en;
    logic       busy;
    logic       done;
    logic [7:0] err_cnt;
    wire  [7:0] DATA_ram;

    logic       start_z;
    logic       busy_z;
    logic       done_z;
    logic [7:0] err_cnt_z;
    wire  [7:0] DATA_ram_z;

    rom_ram_copy_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();
    rom_ram_copy_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_z ();

    rom_ram_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .verify_en (verify_en),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .mem       (mem_if),
        .DATA_ram  (DATA_ram)
    );

    rom_ram_copy_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .START_ADDR (5'd6),
        .END_ADDR   (5'd5)
    ) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_z),
        .verify_en (1'b1),
        .busy      (busy_z),
        .done      (done_z),
        .err_cnt   (err_cnt_z),
        .mem       (mem_z),
        .DATA_ram  (DATA_ram_z)
    );

    assign mem_z.DATA_rom = '0;

    logic [7:0] rom [32];
    logic [7:0] ram [32] = '{default: 8'hEE};
    logic       probe_en;
    logic       fault_on;
    logic       ram_oe;
    logic [7:0] ram_rd;

    assign mem_if.DATA_rom = (!mem_if.CS_rom && mem_if.OE_rom) ? rom[mem_if.ADDR] : 8'h00;
    assign ram_oe = !mem_if.CS_ram && mem_if.OE_ram && !mem_if.WS_ram;
    // The fault flips bit 0 of location 10 as seen on the read path only.
    assign ram_rd = ram[mem_if.ADDR] ^ ((fault_on && mem_if.ADDR == 5'd10) ? 8'h01 : 8'h00);
    assign DATA_ram = ram_oe ? ram_rd : 'z;
    assign DATA_ram = probe_en ? 8'h3C : 'z;

    always @(negedge clk) begin
        if (!mem_if.CS_ram && mem_if.WS_ram) ram[mem_if.ADDR] <= DATA_ram;
    end

    int         viol = 0;
    int         z_strobes = 0;
    logic       prev_ws = 1'b0;
    logic [4:0] prev_addr = '0;

    always @(negedge clk) begin
        if (mem_if.WS_ram && mem_if.OE_ram) viol++;
        if (!mem_if.CS_rom && !mem_if.CS_ram && !(mem_if.OE_ram && mem_if.OE_rom)) viol++;
        if (prev_ws && rst_n && mem_if.ADDR != prev_addr) viol++;
        prev_ws   <= mem_if.WS_ram;
        prev_addr <= mem_if.ADDR;
        if (!mem_z.CS_rom || !mem_z.CS_ram || mem_z.WS_ram || mem_z.OE_ram || mem_z.OE_rom || busy_z)
            z_strobes++;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic [7:0] pm(input logic [7:0] d);
        return {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]};
    endfunction

    // Runs one transfer; lat counts clock edges from the start-sampling edge's predecessor.
    task automatic run_copy(input logic ven, input int restart_at, input logic flt,
                            output int lat, output int pulses, output logic [7:0] err_first);
        int n;
        @(posedge clk); #1;
        start = 1'b1;
        verify_en = ven;
        @(posedge clk); #1;
        start = 1'b0;
        verify_en = ~ven;
        err_first = err_cnt;
        n = 1;
        lat = -1;
        pulses = 0;
        if (done) begin lat = 1; pulses++; end
        while (n < 200 && !(lat > 0 && n >= lat + 3)) begin
            start = (n == restart_at);
            if (flt && mem_if.OE_ram) fault_on = 1'b1;
            @(posedge clk); #1;
            n++;
            if (done) begin
                if (lat < 0) lat = n;
                pulses++;
            end
        end
        start = 1'b0;
        verify_en = 1'b0;
        fault_on = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        verify_en = 1'b0;
        start_z = 1'b0;
        fault_on = 1'b0;
        probe_en = 1'b1;
        for (int unsigned i = 0; i < 32; i++) rom[i] = 8'((i * 37) + 11);
        rom[4] = 8'hA5;
        rom[5] = 8'h01;
        rom[6] = 8'h80;
        rom[9] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, err_cnt} !== 10'h000) $display("FAIL reset_status: busy/done/err=%b/%b/%h, required 0/0/00", busy, done, err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (mem_if.ADDR !== 5'h04) $display("FAIL reset_addr: ADDR=%h, required 04", mem_if.ADDR);
        else pass_cnt++;
        total_cnt++;
        if ({mem_if.CS_rom, mem_if.CS_ram, mem_if.OE_rom, mem_if.OE_ram, mem_if.WS_ram} !== 5'b11000)
            $display("FAIL reset_ctrl: CSrom,CSram,OErom,OEram,WS=%b, required 11000",
                     {mem_if.CS_rom, mem_if.CS_ram, mem_if.OE_rom, mem_if.OE_ram, mem_if.WS_ram});
        else pass_cnt++;
        total_cnt++;
        if (DATA_ram !== 8'h3C) $display("FAIL reset_data_z: DATA_ram=%h with probe 3C, required 3C", DATA_ram);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        probe_en = 1'b0;
    endtask

    task automatic test_copy();
        int lat, pulses, bad;
        logic [7:0] ef;
        int v0;
        v0 = viol;
        run_copy(1'b0, -1, 1'b0, lat, pulses, ef);
        total_cnt++;
        if (lat != 82) $display("FAIL copy_latency: done at %0d, required 82", lat);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 1) $display("FAIL copy_done_pulses: %0d, required 1", pulses);
        else pass_cnt++;
        total_cnt++;
        if ({ram[4], ram[5], ram[6]} !== 24'hCC_80_40)
            $display("FAIL copy_ram456: %h %h %h, required CC 80 40", ram[4], ram[5], ram[6]);
        else pass_cnt++;
        total_cnt++;
        if ({ram[3], ram[31]} !== 16'hEE_EE) $display("FAIL copy_untouched: RAM[3]=%h RAM[31]=%h, required EE EE", ram[3], ram[31]);
        else pass_cnt++;
        bad = 0;
        for (int a = 4; a <= 30; a++) if (ram[a] !== pm(rom[a])) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL copy_window: %0d wrong bytes, required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || err_cnt !== 8'h00) $display("FAIL copy_idle: busy=%b err=%h, required 0 00", busy, err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (viol != v0) $display("FAIL copy_bus_rules: %0d violations, required 0", viol - v0);
        else pass_cnt++;
    endtask

    task automatic test_verify();
        int lat, pulses;
        logic [7:0] ef;
        int v0;
        v0 = viol;
        run_copy(1'b1, -1, 1'b0, lat, pulses, ef);
        total_cnt++;
        if (lat != 109) $display("FAIL verify_latency: done at %0d, required 109", lat);
        else pass_cnt++;
        total_cnt++;
        if (err_cnt !== 8'h00) $display("FAIL verify_err: err_cnt=%h, required 00", err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (viol != v0) $display("FAIL verify_bus_rules: %0d violations, required 0", viol - v0);
        else pass_cnt++;
    endtask

    task automatic test_verify_fault();
        int lat, pulses;
        logic [7:0] ef;
        run_copy(1'b1, -1, 1'b1, lat, pulses, ef);
        total_cnt++;
        if (err_cnt !== 8'h01) $display("FAIL fault_err: err_cnt=%h, required 01", err_cnt);
        else pass_cnt++;
        total_cnt++;
        if (lat != 109 || pulses != 1) $display("FAIL fault_done: at %0d pulses %0d, required 109 1", lat, pulses);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, pulses;
        logic [7:0] ef;
        run_copy(1'b0, 20, 1'b0, lat, pulses, ef);
        total_cnt++;
        if (ef !== 8'h00) $display("FAIL restart_err_clear: err_cnt=%h after start, required 00", ef);
        else pass_cnt++;
        total_cnt++;
        if (lat != 82) $display("FAIL restart_latency: done at %0d, required 82", lat);
        else pass_cnt++;
        total_cnt++;
        if (pulses != 1) $display("FAIL restart_pulses: %0d, required 1", pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, lat, pulses;
        logic [7:0] ef;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(mem_if.WS_ram && mem_if.ADDR == 5'h09) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total_cnt++;
        if (n >= 100) $display("FAIL midreset_reach_wr: WR at 09 not seen, required within 100 cycles");
        else pass_cnt++;
        rst_n = 1'b0;
        probe_en = 1'b1;
        #1;
        total_cnt++;
        if ({mem_if.CS_ram, mem_if.WS_ram, busy} !== 3'b100)
            $display("FAIL midreset_ctrl: CS_ram,WS_ram,busy=%b, required 100", {mem_if.CS_ram, mem_if.WS_ram, busy});
        else pass_cnt++;
        total_cnt++;
        if (DATA_ram !== 8'h3C) $display("FAIL midreset_data_z: DATA_ram=%h with probe 3C, required 3C", DATA_ram);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        probe_en = 1'b0;
        run_copy(1'b0, -1, 1'b0, lat, pulses, ef);
        total_cnt++;
        if (lat != 82 || ram[9] !== 8'hFF || ram[30] !== pm(rom[30]))
            $display("FAIL midreset_rerun: done %0d RAM[9]=%h RAM[30]=%h, required 82 FF %h", lat, ram[9], ram[30], pm(rom[30]));
        else pass_cnt++;
    endtask

    task automatic test_zero_window();
        int z0;
        z0 = z_strobes;
        @(posedge clk); #1;
        start_z = 1'b1;
        @(posedge clk); #1;
        start_z = 1'b0;
        total_cnt++;
        if (done_z !== 1'b1) $display("FAIL zero_done: done=%b one cycle after start, required 1", done_z);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done_z !== 1'b0) $display("FAIL zero_done_width: done=%b next cycle, required 0", done_z);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (z_strobes != z0) $display("FAIL zero_strobes: %0d strobe cycles, required 0", z_strobes - z0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_copy();
        test_verify();
        test_verify_fault();
        test_back_to_back();
        test_reset_mid();
        test_zero_window();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rom_ram_copy_ctrl.md
Name: rom_ram_copy_ctrl

Overview:
- Clocked controller that copies a ROM address window into RAM, bit-permuting each byte in flight.
- Optionally reads the RAM window back afterwards and checks every byte against the permuted ROM value.
- Sits between the asynchronous-read ROM model and the level-write RAM model; it alone drives both memories' chip-selects, enables and shared address.
- Replaces bench-driven copy loops with a synthesizable engine.

Parameters:
- ADDR_W, 5, address width shared by ROM and RAM.
- DATA_W, 8, data width; the permutation below is defined for 8 only.
- START_ADDR, 5'h04, first address copied.
- END_ADDR, 5'h1E, last address copied (inclusive).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- verify_en  in  1  sampled with start; 1 = run readback/compare after copy.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse in DONE.
- err_cnt  out  8  saturating count of verify mismatches; cleared on start.
- ADDR  out  ADDR_W  shared memory address.
- CS_rom  out  1  ROM chip select, active low.
- OE_rom  out  1  ROM output enable, active high.
- DATA_rom  in  DATA_W  ROM read data (combinational).
- CS_ram  out  1  RAM chip select, active low.
- OE_ram  out  1  RAM output enable, active high.
- WS_ram  out  1  RAM write strobe, active high.
- DATA_ram  inout  DATA_W  RAM data; driven only in WR and WR_END, Z otherwise.

Behaviour:
- Reset (async, rst_n=0) forces: state IDLE, busy=0, done=0, err_cnt=0, ADDR=START_ADDR, CS_rom=1, CS_ram=1, OE_rom=0, OE_ram=0, WS_ram=0, DATA_ram=Z.
- Reset mid-operation aborts immediately; RAM contents already written are left as-is.
- Permutation, with d = DATA_rom: perm = {d[0],d[7],d[1],d[6],d[2],d[5],d[3],d[4]}. It is registered into wr_data.
- All outputs are registered, Moore style, from state.
- FSM states and transitions:
  - IDLE: start=1 loads ADDR=START_ADDR, clears err_cnt, latches verify_en. Goes to RD, or to DONE if START_ADDR>END_ADDR (zero transfers).
  - RD (1 cycle): CS_rom=0, OE_rom=1. On exit, wr_data <= perm(DATA_rom). Next: WR.
  - WR (1 cycle): CS_rom=1, OE_rom=0; CS_ram=0, WS_ram=1, OE_ram=0; DATA_ram=wr_data. Next: WR_END.
  - WR_END (1 cycle): WS_ram=0, CS_ram=0; DATA_ram still driven; ADDR unchanged (hold). Next: RD with ADDR+1, or, if ADDR==END_ADDR, VRD with ADDR=START_ADDR when verify enabled, else DONE.
  - VRD (1 cycle): CS_rom=0, OE_rom=1, CS_ram=0, OE_ram=1, WS_ram=0, DATA_ram=Z.
    - On exit, compare DATA_ram with perm(DATA_rom).
    - On mismatch, err_cnt+1, saturating at 8'hFF.
    - Next: VRD with ADDR+1, or DONE when ADDR==END_ADDR.
  - DONE (1 cycle): done=1, busy=0, all memory controls deasserted, ADDR holds its last value. Next: IDLE.
- ADDR changes only on the edge leaving WR_END or VRD, never while WS_ram=1. No wrap-around: ADDR==END_ADDR terminates, including END_ADDR = all ones.
- WS_ram and OE_ram are never both 1. CS_rom and CS_ram may both be 0 only in VRD.
- start while busy, or in DONE, is ignored. verify_en changes during a run are ignored.
- Latency for N = END_ADDR-START_ADDR+1 addresses:
  - done asserts 3N+1 cycles after the start-sampling edge without verify.
  - done asserts 4N+1 cycles after that edge with verify.
  - With START_ADDR>END_ADDR, done asserts 1 cycle after start.

Test Plan:
- ROM[4]=8'hA5, [5]=8'h01, [6]=8'h80, default params, start, verify_en=0 -> RAM[4]=8'hCC, RAM[5]=8'h80, RAM[6]=8'h40. done pulses exactly 82 cycles after start (N=27). RAM[3] and RAM[31] untouched.
- Same run with verify_en=1 -> done 109 cycles after start, err_cnt=0. Checker confirms WS_ram&OE_ram never 1 and ADDR stable whenever WS_ram=1.
- Verify with a fault: bench forces RAM[10] bit0 flipped after the copy phase -> err_cnt=1 at done.
- rst_n pulled low in WR at ADDR=8'h09 -> same cycle: CS_ram=1, WS_ram=0, DATA_ram=Z, busy=0. A fresh start completes normally.
- start pulsed again at cycle 20 of a run -> ignored; a single done pulse occurs. Override START_ADDR=6, END_ADDR=5 -> done 1 cycle after start, no memory strobes.
